mult_div_unit: RTL and testbench

- Multicycle signed MULT/DIV responder for the multicycle MIPS datapath.
- It is the far end of the control_unit's mult_done/div_done/div_zero handshake.
- The control_unit pulses a start request with operands from registers A/B. This block iterates one bit per cycle, writes the 64-bit result into HI/LO, and pulses the matching done strobe.
- Sits beside the ALU. The HI/LO outputs feed mux_high/mux_low.

---
 rtl/mult_div_pkg.sv | 14 +
 rtl/mult_div_unit_div_core.sv | 64 ++++++
 rtl/mult_div_unit.sv | 143 ++++++++++++++
 tb/tb_mult_div_unit.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared state encoding and sizing constants for mult_div_unit
package mult_div_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int ITERATIONS     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mult_div_unit_div_core.sv
// rtl/mult_div_unit_div_core.sv - restoring magnitude divider with signed fix-up, one bit per step
module div_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  divisor_zero
);

  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] quo;
  logic [DATA_WIDTH-1:0] dmag;
  logic                  neg_q;
  logic                  neg_r;

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;
  logic                  fits;
  logic [DATA_WIDTH-1:0] rem_next;
  logic [DATA_WIDTH-1:0] quo_next;
  logic [DATA_WIDTH-1:0] dividend_mag;
  logic [DATA_WIDTH-1:0] divisor_mag;

  // Two's-complement negation of the most negative value yields itself, which is its correct unsigned magnitude.
  assign dividend_mag = dividend[DATA_WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[DATA_WIDTH-1]  ? -divisor  : divisor;

  assign shifted  = {rem, quo[DATA_WIDTH-1]};
  assign fits     = shifted >= {1'b0, dmag};
  assign diff     = shifted - {1'b0, dmag};
  assign rem_next = fits ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
  assign quo_next = {quo[DATA_WIDTH-2:0], fits};

  // Results reflect the step being taken this cycle so the caller can latch them on the final step.
  assign quotient     = neg_q ? -quo_next : quo_next;
  assign remainder    = neg_r ? -rem_next : rem_next;
  assign divisor_zero = (dmag == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      quo   <= '0;
      dmag  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      rem   <= '0;
      quo   <= dividend_mag;
      dmag  <= divisor_mag;
      neg_q <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
      neg_r <= dividend[DATA_WIDTH-1];
    end else if (step) begin
      rem <= rem_next;
      quo <= quo_next;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle signed MULT (radix-2 Booth) / DIV responder writing HI/LO
import mult_div_pkg::*;

module mult_div_unit #(
  parameter int DATA_WIDTH = mult_div_pkg::DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  start_mult,
  input  logic                  start_div,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  mult_done,
  output logic                  div_done,
  output logic                  div_zero,
  output logic                  busy
);

  state_t                state, state_next;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  last_step;
  logic                  op_is_mult;
  logic                  zero_flag;
  logic [DATA_WIDTH-1:0] hi_r, lo_r;

  logic [DATA_WIDTH:0]   acc;
  logic [DATA_WIDTH-1:0] mq;
  logic                  qm1;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH:0]   mcand_ext;
  logic [DATA_WIDTH:0]   booth_sum;
  logic [DATA_WIDTH:0]   acc_sh;
  logic [DATA_WIDTH-1:0] mq_sh;

  logic                  accept;
  logic [DATA_WIDTH-1:0] div_q, div_r;
  logic                  div_by_zero;

  assign accept    = (state == IDLE) && (start_mult || start_div);
  assign last_step = (cnt == CNT_WIDTH'(ITERATIONS - 1));

  div_core #(.DATA_WIDTH(DATA_WIDTH)) u_div_core (
    .clk          (clk),
    .rst_n        (reset_in),
    .start        ((state == IDLE) && !start_mult && start_div),
    .step         (state == DIV),
    .dividend     (op_a),
    .divisor      (op_b),
    .quotient     (div_q),
    .remainder    (div_r),
    .divisor_zero (div_by_zero)
  );

  // Accumulator carries one guard bit so negating the most negative multiplicand cannot overflow.
  assign mcand_ext = {mcand[DATA_WIDTH-1], mcand};

  always_comb begin
    booth_sum = acc;
    case ({mq[0], qm1})
      2'b01:   booth_sum = acc + mcand_ext;
      2'b10:   booth_sum = acc - mcand_ext;
      default: booth_sum = acc;
    endcase
  end

  assign acc_sh = {booth_sum[DATA_WIDTH], booth_sum[DATA_WIDTH:1]};
  assign mq_sh  = {booth_sum[0], mq[DATA_WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_mult)     state_next = MULT;
        else if (start_div) state_next = DIV;
      end
      MULT:    if (last_step) state_next = DONE;
      DIV:     if (div_by_zero || last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      cnt        <= '0;
      op_is_mult <= 1'b0;
      zero_flag  <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
      acc        <= '0;
      mq         <= '0;
      qm1        <= 1'b0;
      mcand      <= '0;
    end else begin
      if (accept) begin
        cnt        <= '0;
        op_is_mult <= start_mult;
        zero_flag  <= 1'b0;
        if (start_mult) begin
          mcand <= op_a;
          mq    <= op_b;
          acc   <= '0;
          qm1   <= 1'b0;
        end
      end else if (state == MULT) begin
        acc <= acc_sh;
        mq  <= mq_sh;
        qm1 <= mq[0];
        cnt <= cnt + CNT_WIDTH'(1);
        if (last_step) begin
          hi_r <= acc_sh[DATA_WIDTH-1:0];
          lo_r <= mq_sh;
        end
      end else if (state == DIV) begin
        if (div_by_zero) begin
          zero_flag <= 1'b1;
        end else begin
          cnt <= cnt + CNT_WIDTH'(1);
          if (last_step) begin
            hi_r <= div_r;
            lo_r <= div_q;
          end
        end
      end
    end
  end

  assign hi        = hi_r;
  assign lo        = lo_r;
  assign busy      = (state != IDLE);
  assign mult_done = (state == DONE) && op_is_mult;
  assign div_done  = (state == DONE) && !op_is_mult;
  assign div_zero  = (state == DONE) && !op_is_mult && zero_flag;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed table-driven checks for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        start_mult, start_div;
  logic [31:0] op_a, op_b;
  logic [31:0] hi, lo;
  logic        mult_done, div_done, div_zero, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk        (clk),
    .reset_in   (reset_in),
    .start_mult (start_mult),
    .start_div  (start_div),
    .op_a       (op_a),
    .op_b       (op_b),
    .hi         (hi),
    .lo         (lo),
    .mult_done  (mult_done),
    .div_done   (div_done),
    .div_zero   (div_zero),
    .busy       (busy)
  );

  typedef struct {
    logic        sm;
    logic        sd;
    logic        inj;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
    logic        exp_md;
    logic        exp_dd;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    logic md, dd, dz;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    start_mult = v.sm;
    start_div  = v.sd;
    op_a       = v.a;
    op_b       = v.b;
    @(posedge clk);
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = $urandom;
    op_b       = $urandom;
    chk({tag, "_busy_run"}, 64'(busy), 64'd1);
    lat = 0;
    while (!(mult_done || div_done) && lat < 40) begin
      if (v.inj && lat == 10) start_div = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
      start_div = 1'b0;
    end
    md = mult_done;
    dd = div_done;
    dz = div_zero;
    chk({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    chk({tag, "_hi"}, 64'(hi), 64'(v.exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(v.exp_lo));
    chk({tag, "_strobes"}, {61'd0, md, dd, dz}, {61'd0, v.exp_md, v.exp_dd, v.exp_dz});
    chk({tag, "_busy_done"}, 64'(busy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_after"}, {60'd0, mult_done, div_done, div_zero, busy}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle"}, {60'd0, mult_done, div_done, div_zero, busy}, 64'd0);
    chk({tag, "_hold"}, {hi, lo}, {v.exp_hi, v.exp_lo});
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 32, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 32, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 32, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'd3,        32'd4,        32'h00000000, 32'h0000000C, 32, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'd5,        32'd0,        32'h00000000, 32'h0000000C, 1,  1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'd6,        32'd3,        32'h00000000, 32'h00000012, 32, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 32, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 32, 1'b0, 1'b1, 1'b0};

    reset_in   = 1'b0;
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = '0;
    op_b       = '0;
    #1;
    chk("reset_outputs", {hi, lo, 28'd0, mult_done, div_done, div_zero, busy}, 64'd0);
    repeat (2) @(negedge clk);
    reset_in = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    start_div = 1'b1;
    op_a      = 32'd1000;
    op_b      = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start_div = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("mid_div_busy", 64'(busy), 64'd1);
    #1 reset_in = 1'b0;
    #1;
    chk("async_reset", {hi, lo, 28'd0, mult_done, div_done, div_zero, busy}, 64'd0);
    repeat (2) @(negedge clk);
    reset_in = 1'b1;
    run_vec(10, '{1'b1, 1'b0, 1'b0, 32'd2, 32'd2, 32'h0, 32'h4, 32, 1'b1, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
